// File: rtl/led_scan_pkg.sv
// Shared types and constants for the LED matrix scan driver and its PWM step counter.
package led_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } scan_state_t;

  localparam int PWM_STEPS  = 16;
  localparam int STEP_W     = 4;
  localparam int FRAME_BITS = 32;

  // The 32-bit frame must map exactly onto the physical array.
  function automatic bit geometry_ok(input int rows, input int cols);
    return (rows * cols) == FRAME_BITS;
  endfunction

endpackage

// File: rtl/led_matrix_scan_driver_if.sv
// Frame/brightness inputs and row/column drive outputs of the LED matrix scan driver.
interface led_matrix_scan_driver_if
  import led_scan_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 8
);

  logic [FRAME_BITS-1:0] frame_i;
  logic                  enable_i;
  logic [STEP_W-1:0]     brightness_i;
  logic [ROWS-1:0]       row_o;
  logic [COLS-1:0]       col_o;
  logic                  frame_sync_o;

  modport master (
    output frame_i, enable_i, brightness_i,
    input  row_o, col_o, frame_sync_o
  );

  modport slave (
    input  frame_i, enable_i, brightness_i,
    output row_o, col_o, frame_sync_o
  );

endinterface

// File: rtl/led_pwm_step_counter.sv
// STEP_CYCLES prescaler feeding a 4-bit PWM step counter; exposes the next step value and a window-end flag.
module led_pwm_step_counter
  import led_scan_pkg::*;
#(
  parameter int STEP_CYCLES = 64
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              run,
  input  logic              clear,
  output logic [STEP_W-1:0] step_next,
  output logic              wrap
);

  localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  logic [PW-1:0]     presc_reg;
  logic [PW-1:0]     presc_next;
  logic [STEP_W-1:0] step_reg;
  logic              tick;

  assign tick = run && (presc_reg == PW'(STEP_CYCLES - 1));
  // wrap marks the last clock of the 16-step on-window
  assign wrap = tick && (step_reg == STEP_W'(PWM_STEPS - 1));

  always_comb begin
    presc_next = presc_reg;
    step_next  = step_reg;
    if (clear) begin
      presc_next = '0;
      step_next  = '0;
    end else if (run) begin
      if (tick) begin
        presc_next = '0;
        step_next  = step_reg + 1'b1;
      end else begin
        presc_next = presc_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      presc_reg <= '0;
      step_reg  <= '0;
    end else begin
      presc_reg <= presc_next;
      step_reg  <= step_next;
    end
  end

endmodule

// File: rtl/led_matrix_scan_driver.sv
// Row-at-a-time scan driver with blanking, 16-step PWM brightness and a frame shadow
// register reloaded at every row-0 blank so CPU writes never tear a scan.
module led_matrix_scan_driver
  import led_scan_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 8,
  parameter int STEP_CYCLES  = 64,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  led_matrix_scan_driver_if.slave  bus
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  if (!geometry_ok(ROWS, COLS)) begin : g_bad_geometry
    $error("led_matrix_scan_driver: ROWS*COLS must equal %0d", FRAME_BITS);
  end

  scan_state_t           state_reg;
  scan_state_t           state_next;
  logic [RW-1:0]         row_reg;
  logic [RW-1:0]         row_next;
  logic [BW-1:0]         blank_cnt_reg;
  logic [BW-1:0]         blank_cnt_next;
  logic [FRAME_BITS-1:0] shadow_reg;
  logic [FRAME_BITS-1:0] shadow_next;
  logic [STEP_W-1:0]     bright_reg;
  logic [STEP_W-1:0]     bright_next;
  logic                  frame_load;

  logic [ROWS-1:0]       row_o_reg;
  logic [ROWS-1:0]       row_o_next;
  logic [COLS-1:0]       col_o_reg;
  logic [COLS-1:0]       col_o_next;
  logic                  sync_reg;
  logic                  sync_next;

  logic                  step_run;
  logic                  step_clear;
  logic                  step_wrap;
  logic [STEP_W-1:0]     step_next;

  logic [COLS-1:0]       frame_rows [ROWS];
  logic [ROWS-1:0]       row_onehot;

  // Counters sit at zero outside ON so every on-window starts at step 0.
  assign step_run   = (state_reg == ON);
  assign step_clear = (state_next != ON);

  led_pwm_step_counter #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_step_counter (
    .clk       (clk_i),
    .srst      (rst_i),
    .run       (step_run),
    .clear     (step_clear),
    .step_next (step_next),
    .wrap      (step_wrap)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      row_reg       <= '0;
      blank_cnt_reg <= '0;
      shadow_reg    <= '0;
      bright_reg    <= '0;
      row_o_reg     <= '0;
      col_o_reg     <= '0;
      sync_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      row_reg       <= row_next;
      blank_cnt_reg <= blank_cnt_next;
      shadow_reg    <= shadow_next;
      bright_reg    <= bright_next;
      row_o_reg     <= row_o_next;
      col_o_reg     <= col_o_next;
      sync_reg      <= sync_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    row_next       = row_reg;
    blank_cnt_next = blank_cnt_reg;
    shadow_next    = shadow_reg;
    bright_next    = bright_reg;
    frame_load     = 1'b0;
    if (!bus.enable_i) begin
      state_next     = IDLE;
      row_next       = '0;
      blank_cnt_next = '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          state_next     = BLANK;
          row_next       = '0;
          blank_cnt_next = '0;
          shadow_next    = bus.frame_i;
          frame_load     = 1'b1;
        end
        BLANK: begin
          if (blank_cnt_reg == BW'(BLANK_CYCLES - 1)) begin
            state_next     = ON;
            blank_cnt_next = '0;
            bright_next    = bus.brightness_i;
          end else begin
            blank_cnt_next = blank_cnt_reg + 1'b1;
          end
        end
        ON: begin
          if (step_wrap) begin
            state_next     = BLANK;
            blank_cnt_next = '0;
            // Wrapping back to row 0 starts a new frame
            if (row_reg == RW'(ROWS - 1)) begin
              row_next    = '0;
              shadow_next = bus.frame_i;
              frame_load  = 1'b1;
            end else begin
              row_next = row_reg + 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_rows
    assign frame_rows[gi] = shadow_next[gi*COLS +: COLS];
    assign row_onehot[gi] = (row_next == RW'(gi));
  end

  // Outputs are derived from next-state values so the registers line up with the state.
  always_comb begin
    row_o_next = '0;
    col_o_next = '0;
    sync_next  = frame_load;
    if (state_next == ON) begin
      row_o_next = row_onehot;
      if (step_next < bright_next) begin
        col_o_next = frame_rows[row_next];
      end
    end
  end

  assign bus.row_o        = row_o_reg;
  assign bus.col_o        = col_o_reg;
  assign bus.frame_sync_o = sync_reg;

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Randomised self-checking bench for led_matrix_scan_driver against a timeline-arithmetic model.
module tb_led_matrix_scan_driver;

  localparam int ROWS         = 4;
  localparam int COLS         = 8;
  localparam int SC           = 2;
  localparam int BC           = 3;
  localparam int ROW_PERIOD   = BC + 16 * SC;
  localparam int FRAME_PERIOD = ROWS * ROW_PERIOD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] frame = '0;
  logic [3:0]  bright = '0;

  int checks = 0;
  int fails = 0;
  int cyc = 0;

  // Reference model: time since scan start decides everything
  bit              m_active = 1'b0;
  int              m_t = 0;
  logic [31:0]     m_shadow = '0;
  int              m_bright = 0;
  logic [ROWS-1:0] exp_row;
  logic [COLS-1:0] exp_col;
  logic            exp_sync;

  led_matrix_scan_driver_if #(.ROWS(ROWS), .COLS(COLS)) bus_if ();

  assign bus_if.frame_i      = frame;
  assign bus_if.enable_i     = en;
  assign bus_if.brightness_i = bright;

  led_matrix_scan_driver #(
    .ROWS         (ROWS),
    .COLS         (COLS),
    .STEP_CYCLES  (SC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // One clock: model observes the same edge as the DUT, outputs are sampled on the falling edge.
  task automatic tick();
    int k;
    int pos;
    int r;
    int s;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_active = 1'b0;
      m_t      = 0;
    end else if (!en) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_t      = 0;
    end else begin
      m_t++;
    end
    exp_row  = '0;
    exp_col  = '0;
    exp_sync = 1'b0;
    if (m_active) begin
      k   = m_t % FRAME_PERIOD;
      pos = k % ROW_PERIOD;
      r   = k / ROW_PERIOD;
      if (k == 0) begin
        m_shadow = frame;
        exp_sync = 1'b1;
      end
      if (pos == BC) m_bright = int'(bright);
      if (pos >= BC) begin
        exp_row = ROWS'(1) << r;
        s = (pos - BC) / SC;
        if (s < m_bright) exp_col = m_shadow[r*COLS +: COLS];
      end
    end
    @(negedge clk);
    if (bus_if.frame_sync_o)
      $display("cycle %0d: frame sync, shadow 0x%08h brightness %0d", cyc, m_shadow, bright);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus_if.row_o, bus_if.col_o, bus_if.frame_sync_o} !== 13'h0) begin
        fails++;
        $display("FAIL reset_values cycle %0d: got row=%h col=%h sync=%b, expected all 0",
                 cyc, bus_if.row_o, bus_if.col_o, bus_if.frame_sync_o);
      end
    end
    rst = 1'b0;
    en  = 1'b0;
    frame = 32'hDEAD_BEEF;
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if ({bus_if.row_o, bus_if.col_o, bus_if.frame_sync_o} !== 13'h0) begin
        fails++;
        $display("FAIL idle_dark cycle %0d: got row=%h col=%h sync=%b, expected all 0",
                 cyc, bus_if.row_o, bus_if.col_o, bus_if.frame_sync_o);
      end
    end
  endtask

  task automatic test_scan_pattern();
    int syncs[$];
    frame  = 32'hA5C3_0FF0;
    bright = 4'd15;
    en     = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus_if.frame_sync_o) syncs.push_back(i);
      checks++;
      if ({bus_if.row_o, bus_if.col_o, bus_if.frame_sync_o} !== {exp_row, exp_col, exp_sync}) begin
        fails++;
        $display("FAIL scan_pattern tick %0d: got row=%h col=%h sync=%b, expected row=%h col=%h sync=%b",
                 i, bus_if.row_o, bus_if.col_o, bus_if.frame_sync_o, exp_row, exp_col, exp_sync);
      end
      checks++;
      if (bus_if.row_o == '0 && bus_if.col_o != '0) begin
        fails++;
        $display("FAIL col_without_row tick %0d: got col=%h, expected 00", i, bus_if.col_o);
      end
    end
    checks++;
    if (syncs.size() != 3 || syncs[0] != 0 || syncs[1] != FRAME_PERIOD || syncs[2] != 2 * FRAME_PERIOD) begin
      fails++;
      $display("FAIL sync_spacing: got %0d pulses (first at %0d), expected 3 at 0/%0d/%0d",
               syncs.size(), (syncs.size() > 0) ? syncs[0] : -1, FRAME_PERIOD, 2 * FRAME_PERIOD);
    end
  endtask

  task automatic test_brightness4();
    int lit = 0;
    en = 1'b0;
    tick();
    frame  = 32'hFFFF_FFFF;
    bright = 4'd4;
    en     = 1'b1;
    for (int i = 0; i < 2 * FRAME_PERIOD; i++) begin
      tick();
      if (bus_if.col_o != '0) lit++;
      checks++;
      if ({bus_if.row_o, bus_if.col_o, bus_if.frame_sync_o} !== {exp_row, exp_col, exp_sync}) begin
        fails++;
        $display("FAIL brightness4 tick %0d: got row=%h col=%h sync=%b, expected row=%h col=%h sync=%b",
                 i, bus_if.row_o, bus_if.col_o, bus_if.frame_sync_o, exp_row, exp_col, exp_sync);
      end
    end
    checks++;
    if (lit != 2 * ROWS * 4 * SC) begin
      fails++;
      $display("FAIL brightness4_duty: got %0d lit clocks, expected %0d", lit, 2 * ROWS * 4 * SC);
    end
  endtask

  task automatic test_frame_change();
    en = 1'b0;
    tick();
    frame  = 32'hA5C3_0FF0;
    bright = 4'd15;
    en     = 1'b1;
    for (int i = 0; i < 2 * FRAME_PERIOD; i++) begin
      tick();
      if (i == 2 * ROW_PERIOD + BC + 10) frame = 32'h0;
      checks++;
      if ({bus_if.row_o, bus_if.col_o, bus_if.frame_sync_o} !== {exp_row, exp_col, exp_sync}) begin
        fails++;
        $display("FAIL frame_change tick %0d: got row=%h col=%h sync=%b, expected row=%h col=%h sync=%b",
                 i, bus_if.row_o, bus_if.col_o, bus_if.frame_sync_o, exp_row, exp_col, exp_sync);
      end
      if (i == 3 * ROW_PERIOD + BC) begin
        checks++;
        if (bus_if.col_o !== 8'hA5) begin
          fails++;
          $display("FAIL old_frame_held tick %0d: got col=%h, expected a5", i, bus_if.col_o);
        end
      end
      if (i == FRAME_PERIOD + BC) begin
        checks++;
        if (bus_if.col_o !== 8'h00 || bus_if.row_o !== 4'h1) begin
          fails++;
          $display("FAIL new_frame_visible tick %0d: got row=%h col=%h, expected row=1 col=00",
                   i, bus_if.row_o, bus_if.col_o);
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    en = 1'b0;
    tick();
    frame  = $urandom() | 32'h0101_0101;
    bright = 4'($urandom_range(15, 1));
    en     = 1'b1;
    for (int i = 0; i < ROW_PERIOD + BC + 12; i++) begin
      tick();
      checks++;
      if ({bus_if.row_o, bus_if.col_o, bus_if.frame_sync_o} !== {exp_row, exp_col, exp_sync}) begin
        fails++;
        $display("FAIL pre_drop tick %0d: got row=%h col=%h sync=%b, expected row=%h col=%h sync=%b",
                 i, bus_if.row_o, bus_if.col_o, bus_if.frame_sync_o, exp_row, exp_col, exp_sync);
      end
    end
    en = 1'b0;
    tick();
    checks++;
    if ({bus_if.row_o, bus_if.col_o, bus_if.frame_sync_o} !== 13'h0) begin
      fails++;
      $display("FAIL enable_drop: got row=%h col=%h sync=%b, expected all 0",
               bus_if.row_o, bus_if.col_o, bus_if.frame_sync_o);
    end
    tick();
    en = 1'b1;
    for (int i = 0; i < ROW_PERIOD + 5; i++) begin
      tick();
      if (i == 0) begin
        checks++;
        if (bus_if.frame_sync_o !== 1'b1 || bus_if.row_o !== 4'h0) begin
          fails++;
          $display("FAIL reenable_sync: got sync=%b row=%h, expected sync=1 row=0",
                   bus_if.frame_sync_o, bus_if.row_o);
        end
      end
      if (i == BC) begin
        checks++;
        if (bus_if.row_o !== 4'h1) begin
          fails++;
          $display("FAIL reenable_row0: got row=%h, expected 1", bus_if.row_o);
        end
      end
      checks++;
      if ({bus_if.row_o, bus_if.col_o, bus_if.frame_sync_o} !== {exp_row, exp_col, exp_sync}) begin
        fails++;
        $display("FAIL post_reenable tick %0d: got row=%h col=%h sync=%b, expected row=%h col=%h sync=%b",
                 i, bus_if.row_o, bus_if.col_o, bus_if.frame_sync_o, exp_row, exp_col, exp_sync);
      end
    end
  endtask

  task automatic test_reset_midscan();
    frame  = $urandom();
    bright = 4'($urandom_range(15, 0));
    for (int i = 0; i < 60; i++) tick();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({bus_if.row_o, bus_if.col_o, bus_if.frame_sync_o} !== 13'h0) begin
        fails++;
        $display("FAIL reset_midscan cycle %0d: got row=%h col=%h sync=%b, expected all 0",
                 cyc, bus_if.row_o, bus_if.col_o, bus_if.frame_sync_o);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < FRAME_PERIOD + 10; i++) begin
      tick();
      checks++;
      if ({bus_if.row_o, bus_if.col_o, bus_if.frame_sync_o} !== {exp_row, exp_col, exp_sync}) begin
        fails++;
        $display("FAIL restart_after_reset tick %0d: got row=%h col=%h sync=%b, expected row=%h col=%h sync=%b",
                 i, bus_if.row_o, bus_if.col_o, bus_if.frame_sync_o, exp_row, exp_col, exp_sync);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 1500; i++) begin
      frame  = $urandom();
      bright = 4'($urandom_range(15, 0));
      if ($urandom_range(99, 0) < 2) en = ~en;
      rst = ($urandom_range(199, 0) == 0);
      tick();
      checks++;
      if ({bus_if.row_o, bus_if.col_o, bus_if.frame_sync_o} !== {exp_row, exp_col, exp_sync}) begin
        fails++;
        $display("FAIL random_scan tick %0d: got row=%h col=%h sync=%b, expected row=%h col=%h sync=%b",
                 i, bus_if.row_o, bus_if.col_o, bus_if.frame_sync_o, exp_row, exp_col, exp_sync);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_pattern();
    test_brightness4();
    test_frame_change();
    test_enable_drop();
    test_reset_midscan();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
